// File: rtl/loan_io_uart.sv
// 8N1 UART on the HPS loan-I/O bus: loan line 49 is RX, loan line 50 is TX.
// Bytes are exchanged with the AES datapath over valid/ready streams.
module loan_io_uart #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [66:0] loan_io_in,
  output logic [66:0] loan_io_out,
  output logic [66:0] loan_io_oe,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_frame_err,
  output logic        rx_overrun
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  tx_state_t     tx_state_r, tx_state_s;
  logic [CW-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]    tx_bit_r, tx_bit_s;
  logic [7:0]    tx_shift_r, tx_shift_s;
  logic          tx_line_r, tx_line_s;
  logic          tx_ready_r, tx_ready_s;

  rx_state_t     rx_state_r, rx_state_s;
  logic [CW-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]    rx_bit_r, rx_bit_s;
  logic [7:0]    rx_shift_r, rx_shift_s;
  logic [7:0]    rx_data_r, rx_data_s;
  logic          rx_valid_r, rx_valid_s;
  logic          rx_err_r, rx_err_s;
  logic          rx_ovr_r, rx_ovr_s;
  logic          sync1_r, rxs_r, rxs_prev_r;

  logic          unused_loan_in_s;

  assign unused_loan_in_s = ^{loan_io_in[66:50], loan_io_in[48:0]};

  assign loan_io_out  = {16'h0000, tx_line_r, 50'h0};
  assign loan_io_oe   = 67'h0_0004_0000_0000_0000;
  assign tx_ready     = tx_ready_r;
  assign rx_data      = rx_data_r;
  assign rx_valid     = rx_valid_r;
  assign rx_frame_err = rx_err_r;
  assign rx_overrun   = rx_ovr_r;

  // TX state register; the line idles high so reset drives it to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_line_r  <= 1'b1;
      tx_ready_r <= 1'b1;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      tx_line_r  <= tx_line_s;
      tx_ready_r <= tx_ready_s;
    end
  end

  // TX next state: the line value is computed one cycle ahead and registered.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    tx_line_s  = tx_line_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_valid && tx_ready_r) begin
          tx_state_s = TX_START;
          tx_cnt_s   = CNT_ZERO;
          tx_shift_s = tx_data;
          tx_line_s  = 1'b0;
        end else begin
          tx_line_s  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_state_s = TX_DATA;
          tx_cnt_s   = CNT_ZERO;
          tx_bit_s   = 3'd0;
          tx_line_s  = tx_shift_r[0];
          tx_shift_s = {1'b0, tx_shift_r[7:1]};
        end else begin
          tx_cnt_s   = tx_cnt_r + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_bit_r == 3'd7) begin
            tx_state_s = TX_STOP;
            tx_line_s  = 1'b1;
          end else begin
            tx_bit_s   = tx_bit_r + 3'd1;
            tx_line_s  = tx_shift_r[0];
            tx_shift_s = {1'b0, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_state_s = TX_IDLE;
          tx_cnt_s   = CNT_ZERO;
        end else begin
          tx_cnt_s   = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_line_s  = 1'b1;
      end
    endcase
    tx_ready_s = (tx_state_s == TX_IDLE);
  end

  // RX synchroniser, edge-detect history and RX state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      rx_ovr_r   <= 1'b0;
    end else begin
      sync1_r    <= loan_io_in[49];
      rxs_r      <= sync1_r;
      rxs_prev_r <= rxs_r;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      rx_err_r   <= rx_err_s;
      rx_ovr_r   <= rx_ovr_s;
    end
  end

  // RX next state: a load in the same cycle as a consume keeps rx_valid set.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    rx_err_s   = 1'b0;
    rx_ovr_s   = 1'b0;
    if (rx_valid_r && rx_ready) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
    end
    case (rx_state_r)
      RX_IDLE: begin
        if (rxs_prev_r && !rxs_r) begin
          rx_state_s = RX_START;
          rx_cnt_s   = CNT_ZERO;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = CNT_ZERO;
          rx_bit_s = 3'd0;
          if (rxs_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rxs_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_bit_s   = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s = CNT_ZERO;
          if (rxs_r) begin
            rx_state_s = RX_IDLE;
            if (!rx_valid_r || rx_ready) begin
              rx_data_s  = rx_shift_r;
              rx_valid_s = 1'b1;
            end else begin
              rx_ovr_s   = 1'b1;
            end
          end else begin
            rx_err_s   = 1'b1;
            rx_state_s = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs_r) begin
          rx_state_s = RX_IDLE;
        end else begin
          rx_state_s = RX_WAIT_HIGH;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_loan_io_uart.sv
// Self-checking bench for loan_io_uart at CLKS_PER_BIT=10 with a frame-level
// reference: expected line levels and receive events come from 8N1 timing rules.
module tb_loan_io_uart;

  localparam int N = 10;
  localparam int RX_RISE = N / 2 + 9 * N + 3;  // pin start edge to rx_valid
  localparam logic [66:0] OE_EXP = 67'h0_0004_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [66:0] loan_io_in;
  logic [66:0] loan_io_out;
  logic [66:0] loan_io_oe;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_frame_err;
  logic        rx_overrun;

  int n_checks = 0;
  int n_errors = 0;

  loan_io_uart #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .clk(clk), .reset_n(reset_n),
    .loan_io_in(loan_io_in), .loan_io_out(loan_io_out), .loan_io_oe(loan_io_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one TX frame starting in cycle 1 after the handshake edge.
  task automatic tx_frame_check(input logic [7:0] b, input logic [7:0] nxt, input logic chain);
    logic [9:0]  fr;
    logic        exp_line;
    logic [66:0] exp_out;
    fr = {1'b1, b, 1'b0};
    for (int c = 1; c <= 10 * N + 1; c++) begin
      exp_line = (c <= 10 * N) ? fr[(c - 1) / N] : 1'b1;
      exp_out  = {16'h0000, exp_line, 50'h0};
      n_checks++;
      if (loan_io_out !== exp_out) begin
        n_errors++;
        $display("FAIL tx_line byte=%h cycle=%0d got=%b exp=%b", b, c, loan_io_out[50], exp_line);
      end
      n_checks++;
      if (tx_ready !== (c == 10 * N + 1)) begin
        n_errors++;
        $display("FAIL tx_ready byte=%h cycle=%0d got=%b", b, c, tx_ready);
      end
      n_checks++;
      if (loan_io_oe !== OE_EXP) begin
        n_errors++;
        $display("FAIL tx_oe cycle=%0d got=%h exp=%h", c, loan_io_oe, OE_EXP);
      end
      if (c == 10 * N + 1 && chain) tx_data = nxt;
      if (c < 10 * N + 1) tick();
    end
  endtask

  // Drives one RX frame on the pin and counts the receiver's events.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int extra, input int ready_at,
                          output int err_n, output int ovr_n, output int rise_at);
    logic [9:0] fr;
    logic       prev_v;
    fr = {stop, b, 1'b0};
    prev_v = rx_valid;
    err_n = 0;
    ovr_n = 0;
    rise_at = -1;
    for (int c = 0; c < 10 * N + extra; c++) begin
      loan_io_in[49] = (c < 10 * N) ? fr[c / N] : stop;
      rx_ready = (c == ready_at);
      tick();
      if (rx_frame_err) err_n++;
      if (rx_overrun) ovr_n++;
      if (rx_valid && !prev_v && rise_at < 0) rise_at = c + 1;
      prev_v = rx_valid;
    end
    rx_ready = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    loan_io_in = {67{1'b1}};
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (loan_io_out !== {16'h0000, 1'b1, 50'h0}) begin
        n_errors++; $display("FAIL reset_out phase=%0d got=%h", p, loan_io_out);
      end
      n_checks++;
      if (loan_io_oe !== OE_EXP) begin
        n_errors++; $display("FAIL reset_oe phase=%0d got=%h exp=%h", p, loan_io_oe, OE_EXP);
      end
      n_checks++;
      if ({tx_ready, rx_valid, rx_data, rx_frame_err, rx_overrun} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL reset_flags phase=%0d got rdy=%b v=%b d=%h fe=%b ov=%b exp 1 0 00 0 0",
                 p, tx_ready, rx_valid, rx_data, rx_frame_err, rx_overrun);
      end
      if (p == 0) begin
        reset_n = 1'b1;
        repeat (3) tick();
      end
    end
  endtask

  task automatic test_tx(input logic [7:0] b);
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++; $display("FAIL tx_idle_ready got=%b exp=1", tx_ready);
    end
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_frame_check(b, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bq [3];
    for (int i = 0; i < 3; i++) bq[i] = 8'($urandom_range(0, 255));
    tx_data = bq[0]; tx_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tx_frame_check(bq[i], (i < 2) ? bq[(i < 2) ? i + 1 : 0] : 8'h00, i < 2);
      if (i < 2) tick();
    end
    tx_valid = 1'b0;
    tick();
  endtask

  task automatic test_rx_basic();
    int e, o, r;
    rx_frame(8'h3C, 1'b1, 5, -1, e, o, r);
    n_checks++;
    if (r !== RX_RISE) begin n_errors++; $display("FAIL rx_rise got=%0d exp=%0d", r, RX_RISE); end
    n_checks++;
    if (rx_data !== 8'h3C) begin n_errors++; $display("FAIL rx_data got=%h exp=3c", rx_data); end
    n_checks++;
    if (e !== 0 || o !== 0) begin n_errors++; $display("FAIL rx_no_err got fe=%0d ov=%0d exp 0 0", e, o); end
  endtask

  task automatic test_overrun();
    int e, o, r;
    rx_frame(8'h55, 1'b1, 5, -1, e, o, r);
    n_checks++;
    if (o !== 1 || e !== 0) begin n_errors++; $display("FAIL ovr_pulse got ov=%0d fe=%0d exp 1 0", o, e); end
    n_checks++;
    if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
      n_errors++; $display("FAIL ovr_hold got d=%h v=%b exp 3c 1", rx_data, rx_valid);
    end
    consume();
    n_checks++;
    if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_consume got v=%b exp 0", rx_valid); end
  endtask

  task automatic test_load_wins();
    int e, o, r;
    logic [7:0] b1, b2;
    b1 = 8'($urandom_range(0, 255));
    b2 = ~b1;
    rx_frame(b1, 1'b1, 5, -1, e, o, r);
    rx_frame(b2, 1'b1, 5, RX_RISE - 1, e, o, r);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== b2 || o !== 0) begin
      n_errors++; $display("FAIL load_wins got v=%b d=%h ov=%0d exp 1 %h 0", rx_valid, rx_data, o, b2);
    end
    consume();
  endtask

  // Random frames against a one-entry holding-register model.
  task automatic test_rx_random();
    int e, o, r;
    logic       m_valid;
    logic [7:0] m_data, b;
    m_valid = 1'b0;
    m_data  = rx_data;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_frame(b, 1'b1, $urandom_range(2, 8), -1, e, o, r);
      n_checks++;
      if (o !== (m_valid ? 1 : 0) || e !== 0) begin
        n_errors++; $display("FAIL rnd_events i=%0d got ov=%0d fe=%0d exp ov=%0d", i, o, e, m_valid);
      end
      if (!m_valid) begin
        n_checks++;
        if (r !== RX_RISE) begin n_errors++; $display("FAIL rnd_rise i=%0d got=%0d exp=%0d", i, r, RX_RISE); end
        m_data = b;
        m_valid = 1'b1;
      end
      n_checks++;
      if (rx_valid !== m_valid || rx_data !== m_data) begin
        n_errors++; $display("FAIL rnd_hold i=%0d got v=%b d=%h exp v=%b d=%h", i, rx_valid, rx_data, m_valid, m_data);
      end
      if ($urandom_range(0, 1) == 1) begin
        consume();
        m_valid = 1'b0;
      end
    end
    if (m_valid) consume();
  endtask

  task automatic test_frame_err();
    int e, o, r;
    int e2;
    rx_frame(8'hFF, 1'b0, 30, -1, e, o, r);
    n_checks++;
    if (e !== 1 || o !== 0 || rx_valid !== 1'b0) begin
      n_errors++; $display("FAIL frame_err got fe=%0d ov=%0d v=%b exp 1 0 0", e, o, rx_valid);
    end
    e2 = 0;
    loan_io_in[49] = 1'b1;
    repeat (6) begin
      tick();
      if (rx_frame_err || rx_valid) e2++;
    end
    rx_frame(8'h5A, 1'b1, 5, -1, e, o, r);
    n_checks++;
    if (e2 !== 0 || r !== RX_RISE || rx_data !== 8'h5A || e !== 0) begin
      n_errors++; $display("FAIL frame_err_recover got spur=%0d rise=%0d d=%h fe=%0d exp 0 %0d 5a 0", e2, r, rx_data, e, RX_RISE);
    end
    consume();
  endtask

  task automatic test_glitch();
    int e, o, r;
    int spur;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    spur = 0;
    loan_io_in[49] = 1'b0;
    repeat (3) begin tick(); if (rx_frame_err || rx_valid || rx_overrun) spur++; end
    loan_io_in[49] = 1'b1;
    repeat (4) begin tick(); if (rx_frame_err || rx_valid || rx_overrun) spur++; end
    rx_frame(b, 1'b1, 5, -1, e, o, r);
    n_checks++;
    if (spur !== 0 || e !== 0 || o !== 0) begin
      n_errors++; $display("FAIL glitch_quiet got spur=%0d fe=%0d ov=%0d exp 0 0 0", spur, e, o);
    end
    n_checks++;
    if (r !== RX_RISE || rx_data !== b) begin
      n_errors++; $display("FAIL glitch_next got rise=%0d d=%h exp %0d %h", r, rx_data, RX_RISE, b);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int e, o, r;
    logic [9:0] fr;
    logic       prev_v;
    rx_frame(8'h77, 1'b1, 5, -1, e, o, r);
    tx_data = 8'h96; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    fr = {1'b1, 8'h00, 1'b0};
    for (int c = 0; c < 45; c++) begin
      loan_io_in[49] = fr[c / N];
      tick();
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (loan_io_out !== {16'h0000, 1'b1, 50'h0} || tx_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid_tx got line=%b rdy=%b exp 1 1", loan_io_out[50], tx_ready);
    end
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_mid_rx got v=%b d=%h exp 0 00", rx_valid, rx_data);
    end
    loan_io_in[49] = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    tx_data = 8'h01; tx_valid = 1'b1;
    prev_v = rx_valid;
    r = -1;
    e = 0;
    for (int c = 0; c < 10 * N + 30; c++) begin
      loan_io_in[49] = loan_io_out[50];
      tick();
      tx_valid = 1'b0;
      if (rx_frame_err) e++;
      if (rx_valid && !prev_v && r < 0) r = c;
      prev_v = rx_valid;
    end
    n_checks++;
    if (r < 0 || rx_data !== 8'h01 || e !== 0) begin
      n_errors++; $display("FAIL loopback got rise=%0d d=%h fe=%0d exp d=01 fe=0", r, rx_data, e);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_tx(8'hA5);
    for (int i = 0; i < 3; i++) test_tx(8'($urandom_range(0, 255)));
    test_back_to_back();
    test_rx_basic();
    test_overrun();
    test_load_wins();
    test_rx_random();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
